mem_loader: RTL and testbench

MEM_LOADER -- requirements
Module: mem_loader

---
 rtl/mem_loader_pkg.sv | 28 ++
 rtl/mem_loader_word_packer.sv | 61 ++++++
 rtl/mem_loader.sv | 190 +++++++++++++++++++
 tb/tb_mem_loader.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_loader_pkg.sv
// mem_loader_pkg: shared types and constants for the UART program/data loader.
// Holds the loader FSM state encoding, the NI byte code meaning "fill the whole
// instruction RAM", the byte order of multi-byte data words and a word-size helper.
package mem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    INS_CNT    = 3'd1,
    INS_DATA   = 3'd2,
    DAT_CNT_LO = 3'd3,
    DAT_CNT_HI = 3'd4,
    DAT_DATA   = 3'd5,
    CHECK      = 3'd6,
    DONE       = 3'd7
  } loader_state_t;

  // An instruction count byte of zero stands for a full instruction RAM.
  localparam logic [7:0] NI_FULL_CODE = 8'h00;

  // Data words arrive least-significant byte first.
  localparam bit LITTLE_ENDIAN = 1'b1;

  // Number of stream bytes carrying one data word of w bits.
  function automatic int bytes_per_word(input int w);
    return (w + 7) / 8;
  endfunction

endpackage

// File: rtl/mem_loader_word_packer.sv
// word_packer: gathers B = ceil(W/8) stream bytes into one W-bit data word.
// Ports: clk, rstN (sync, active-low), clear (restart at byte 0), byte_vld/byte_dat
// (accepted byte), last (next byte completes a word), word_vld/word_dat (registered word, 1-cycle pulse).
module word_packer
  import mem_loader_pkg::*;
#(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rstN,
  input  logic         clear,
  input  logic         byte_vld,
  input  logic [7:0]   byte_dat,
  output logic         last,
  output logic         word_vld,
  output logic [W-1:0] word_dat
);

  localparam int B  = bytes_per_word(W);
  localparam int IW = (B > 1) ? $clog2(B) : 1;

  logic [IW-1:0]  idx;
  logic [IW-1:0]  slot;
  logic [8*B-1:0] acc;
  logic [8*B-1:0] acc_next;

  assign last = (idx == IW'(B - 1));

  // Merge the incoming byte into its lane so the completed word can be
  // registered in the same cycle as its final byte.
  always_comb begin
    slot     = LITTLE_ENDIAN ? idx : (IW'(B - 1) - idx);
    acc_next = acc;
    acc_next[{slot, 3'b000} +: 8] = byte_dat;
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      idx      <= '0;
      acc      <= '0;
      word_vld <= 1'b0;
      word_dat <= '0;
    end else begin
      word_vld <= 1'b0;
      if (clear) begin
        idx <= '0;
      end else if (byte_vld) begin
        acc <= acc_next;
        if (last) begin
          idx      <= '0;
          word_vld <= 1'b1;
          // Bits above W in the final byte are dropped here.
          word_dat <= acc_next[W-1:0];
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_loader.sv
// mem_loader: receives a UART byte stream and writes it into instruction and data RAMs.
// Ports: clk, rstN (sync, active-low), start, rx_data/rx_valid/rx_ready (byte handshake),
// insMem*/dataMem* (RAM write ports, registered, 1-cycle strobes), busy, loadDone, error.
// Option: define LOADER_CHECKSUM_EN to expect a trailing XOR checksum byte and drive error.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int CORE_COUNT     = 1,
  parameter int REG_WIDTH      = 12,
  parameter int INS_WIDTH      = 8,
  parameter int INS_MEM_DEPTH  = 256,
  parameter int DATA_MEM_DEPTH = 4096,
  localparam int W  = CORE_COUNT * REG_WIDTH,
  localparam int IA = $clog2(INS_MEM_DEPTH),
  localparam int DA = $clog2(DATA_MEM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 start,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic                 insMemWrEn,
  output logic [IA-1:0]        insMemAddr,
  output logic [INS_WIDTH-1:0] insMemData,
  output logic                 dataMemWrEn,
  output logic [DA-1:0]        dataMemAddr,
  output logic [W-1:0]         dataMemData,
  output logic                 busy,
  output logic                 loadDone,
  output logic                 error
);

`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_t AFTER_DATA = CHECK;
`else
  localparam loader_state_t AFTER_DATA = DONE;
`endif

  loader_state_t state;
  loader_state_t state_next;

  logic          accept;
  logic          load_start;
  logic [IA-1:0] ins_cnt;
  logic [IA-1:0] ins_last;
  logic [7:0]    nd_lo;
  logic [DA-1:0] nd_val;
  logic [DA-1:0] nd_last;
  logic [DA-1:0] word_cnt;
  logic          pk_last;
  logic          pk_byte;

  assign accept     = rx_valid && rx_ready;
  assign load_start = start && ((state == IDLE) || (state == DONE));
  // Only the low DA bits of the 16-bit word count are meaningful.
  assign nd_val     = DA'({rx_data, nd_lo});
  assign pk_byte    = accept && (state == DAT_DATA);

  always_ff @(posedge clk) begin
    if (!rstN) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b1;
    rx_ready   = 1'b0;
    loadDone   = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = INS_CNT;
      end
      INS_CNT: begin
        rx_ready = 1'b1;
        if (accept) state_next = INS_DATA;
      end
      INS_DATA: begin
        rx_ready = 1'b1;
        if (accept && (ins_cnt == ins_last)) state_next = DAT_CNT_LO;
      end
      DAT_CNT_LO: begin
        rx_ready = 1'b1;
        if (accept) state_next = DAT_CNT_HI;
      end
      DAT_CNT_HI: begin
        rx_ready = 1'b1;
        if (accept) state_next = (nd_val != '0) ? DAT_DATA : AFTER_DATA;
      end
      DAT_DATA: begin
        rx_ready = 1'b1;
        if (accept && pk_last && (word_cnt == nd_last)) state_next = AFTER_DATA;
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        rx_ready = 1'b1;
        if (accept) state_next = DONE;
      end
`endif
      DONE: begin
        busy     = 1'b0;
        loadDone = 1'b1;
        if (start) state_next = INS_CNT;
      end
      default: begin
        busy       = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // Counters and the registered instruction write port.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      ins_cnt     <= '0;
      ins_last    <= '0;
      nd_lo       <= '0;
      nd_last     <= '0;
      word_cnt    <= '0;
      insMemWrEn  <= 1'b0;
      insMemAddr  <= '0;
      insMemData  <= '0;
      dataMemAddr <= '0;
    end else begin
      insMemWrEn <= 1'b0;
      if (load_start) begin
        ins_cnt  <= '0;
        word_cnt <= '0;
      end
      if (accept) begin
        case (state)
          INS_CNT: begin
            ins_last <= (rx_data == NI_FULL_CODE) ? IA'(INS_MEM_DEPTH - 1)
                                                  : IA'(rx_data - 8'd1);
          end
          INS_DATA: begin
            insMemWrEn <= 1'b1;
            insMemAddr <= ins_cnt;
            insMemData <= INS_WIDTH'(rx_data);
            ins_cnt    <= ins_cnt + 1'b1;
          end
          DAT_CNT_LO: nd_lo <= rx_data;
          // Only used when the count is non-zero, so the decrement never underflows in use.
          DAT_CNT_HI: nd_last <= nd_val - 1'b1;
          DAT_DATA: begin
            if (pk_last) begin
              dataMemAddr <= word_cnt;
              word_cnt    <= word_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Data word strobe and payload come straight from the packer's registers,
  // landing one cycle after the word's final byte, alongside dataMemAddr.
  word_packer #(.W(W)) u_packer (
    .clk      (clk),
    .rstN     (rstN),
    .clear    (load_start),
    .byte_vld (pk_byte),
    .byte_dat (rx_data),
    .last     (pk_last),
    .word_vld (dataMemWrEn),
    .word_dat (dataMemData)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      csum  <= '0;
      error <= 1'b0;
    end else if (load_start) begin
      csum  <= '0;
      error <= 1'b0;
    end else if (accept) begin
      if (state == CHECK) error <= (rx_data != csum);
      else                csum  <= csum ^ rx_data;
    end
  end
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: randomized and directed stream loads against a stream-parsing reference model.
// Drives a default instance (W=12) and a CORE_COUNT=2 instance (W=24) through one shared byte driver.
// Honours LOADER_CHECKSUM_EN by appending a good or corrupted trailing checksum byte.
module tb_mem_loader;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       start = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       sel = 1'b0;

  logic        rdy1, iwe1, dwe1, busy1, done1, err1;
  logic [7:0]  ia1, id1;
  logic [11:0] da1, dd1;
  logic        rdy2, iwe2, dwe2, busy2, done2, err2;
  logic [7:0]  ia2, id2;
  logic [11:0] da2;
  logic [23:0] dd2;

  always #5 clk = ~clk;

  mem_loader dut (
    .clk(clk), .rstN(rstN), .start(start & ~sel), .rx_data(rx_data),
    .rx_valid(rx_valid & ~sel), .rx_ready(rdy1), .insMemWrEn(iwe1), .insMemAddr(ia1),
    .insMemData(id1), .dataMemWrEn(dwe1), .dataMemAddr(da1), .dataMemData(dd1),
    .busy(busy1), .loadDone(done1), .error(err1)
  );

  mem_loader #(.CORE_COUNT(2)) dut2 (
    .clk(clk), .rstN(rstN), .start(start & sel), .rx_data(rx_data),
    .rx_valid(rx_valid & sel), .rx_ready(rdy2), .insMemWrEn(iwe2), .insMemAddr(ia2),
    .insMemData(id2), .dataMemWrEn(dwe2), .dataMemAddr(da2), .dataMemData(dd2),
    .busy(busy2), .loadDone(done2), .error(err2)
  );

  wire        m_rdy  = sel ? rdy2  : rdy1;
  wire        m_iwe  = sel ? iwe2  : iwe1;
  wire        m_dwe  = sel ? dwe2  : dwe1;
  wire        m_busy = sel ? busy2 : busy1;
  wire        m_done = sel ? done2 : done1;
  wire        m_err  = sel ? err2  : err1;
  wire [7:0]  m_ia   = sel ? ia2   : ia1;
  wire [7:0]  m_id   = sel ? id2   : id1;
  wire [11:0] m_da   = sel ? da2   : da1;
  wire [23:0] m_dd   = sel ? dd2   : {12'h000, dd1};

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  stream[$];
  int          exp_ia[$];
  logic [63:0] exp_id[$];
  int          exp_da[$];
  logic [63:0] exp_dd[$];
  int          got_ia[$];
  logic [63:0] got_id[$];
  int          got_da[$];
  logic [63:0] got_dd[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_iwe) begin got_ia.push_back(int'(m_ia)); got_id.push_back(64'(m_id)); end
    if (m_dwe) begin got_da.push_back(int'(m_da)); got_dd.push_back(64'(m_dd)); end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_got();
    got_ia.delete(); got_id.delete(); got_da.delete(); got_dd.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps, input bit mid_start);
    bit ok;
    if (gaps) repeat ($urandom_range(0, 2)) step();
    rx_data  = b;
    rx_valid = 1'b1;
    start    = mid_start && ($urandom_range(0, 5) == 0);
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (m_rdy) begin ok = 1'b1; break; end
    end
    if (!ok) check("rx_ready_timeout", 0, 1);
    step();
    rx_valid = 1'b0;
    start    = 1'b0;
  endtask

  // Parse the stream by its format rules to get the expected RAM writes,
  // then play it through the selected DUT and compare.
  task automatic run_load(input string name, input bit bad, input bit gaps, input bit mid_start);
    int p, ni, nd, wid, bsz;
    logic [7:0] x;
    logic [63:0] v;
    bit exp_err, ok;
    wid = sel ? 24 : 12;
    bsz = (wid + 7) / 8;
    exp_ia.delete(); exp_id.delete(); exp_da.delete(); exp_dd.delete();
    x = 8'h00;
    foreach (stream[i]) x ^= stream[i];
    ni = (stream[0] == 8'h00) ? 256 : int'(stream[0]);
    p = 1;
    for (int k = 0; k < ni; k++) begin
      exp_ia.push_back(k);
      exp_id.push_back(64'(stream[p]));
      p++;
    end
    nd = (int'(stream[p]) + int'(stream[p+1]) * 256) % 4096;
    p += 2;
    for (int j = 0; j < nd; j++) begin
      v = 64'h0;
      for (int b = 0; b < bsz; b++) begin
        v += 64'(stream[p]) * (64'd1 << (8 * b));
        p++;
      end
      exp_da.push_back(j);
      exp_dd.push_back(v % (64'd1 << wid));
    end
    exp_err = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    stream.push_back(bad ? (x ^ 8'h01) : x);
    exp_err = bad;
`else
    if (bad) exp_err = 1'b0;
`endif
    clear_got();
    start = 1'b1;
    step();
    start = 1'b0;
    foreach (stream[i]) send_byte(stream[i], gaps, mid_start);
    ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (m_done) begin ok = 1'b1; break; end
    end
    if (!ok) check({name, "_done_timeout"}, 0, 1);
    repeat (2) @(negedge clk);
    check({name, "_loadDone"}, 64'(m_done), 1);
    check({name, "_busy"}, 64'(m_busy), 0);
    check({name, "_rx_ready"}, 64'(m_rdy), 0);
    check({name, "_error"}, 64'(m_err), 64'(exp_err));
    check({name, "_ins_count"}, got_ia.size(), exp_ia.size());
    for (int i = 0; i < exp_ia.size() && i < got_ia.size(); i++) begin
      check({name, "_ins_addr"}, got_ia[i], exp_ia[i]);
      check({name, "_ins_data"}, got_id[i], exp_id[i]);
    end
    check({name, "_dat_count"}, got_da.size(), exp_da.size());
    for (int i = 0; i < exp_da.size() && i < got_da.size(); i++) begin
      check({name, "_dat_addr"}, got_da[i], exp_da[i]);
      check({name, "_dat_data"}, got_dd[i], exp_dd[i]);
    end
    step();
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_busy"}, 64'(m_busy), 0);
    check({name, "_rx_ready"}, 64'(m_rdy), 0);
    check({name, "_loadDone"}, 64'(m_done), 0);
    check({name, "_error"}, 64'(m_err), 0);
    check({name, "_ins_we"}, 64'(m_iwe), 0);
    check({name, "_ins_addr"}, 64'(m_ia), 0);
    check({name, "_dat_we"}, 64'(m_dwe), 0);
    check({name, "_dat_data"}, 64'(m_dd), 0);
  endtask

  initial begin
    int ni, nd, ni_byte;
    repeat (3) step();
    @(negedge clk);
    check_idle_outputs("reset_a");
    sel = 1'b1; #1;
    check_idle_outputs("reset_b");
    sel = 1'b0;
    step();
    rstN = 1'b1;
    step();

    // Three instructions, no data.
    stream = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00};
    run_load("three_ins", 1'b0, 1'b0, 1'b0);

    // 12-bit words: upper nibble of each high byte is discarded.
    stream = '{8'h01, 8'hAA, 8'h02, 8'h00, 8'h34, 8'hF2, 8'h78, 8'h05};
    run_load("w12_words", 1'b0, 1'b0, 1'b0);

    // Checksum pair (good and corrupted trailing byte when the option is built in).
    stream = '{8'h01, 8'hAA, 8'h00, 8'h00};
    run_load("csum_bad", 1'b1, 1'b0, 1'b0);
    stream = '{8'h01, 8'hAA, 8'h00, 8'h00};
    run_load("csum_good", 1'b0, 1'b0, 1'b0);

    // NI of zero fills the entire instruction RAM.
    stream.delete();
    stream.push_back(8'h00);
    for (int k = 0; k < 256; k++) stream.push_back(8'($urandom));
    stream.push_back(8'h01); stream.push_back(8'h00);
    stream.push_back(8'($urandom)); stream.push_back(8'($urandom));
    run_load("ni_full", 1'b0, 1'b0, 1'b0);

    // Random loads, with idle gaps, ignored mid-load starts and junk in the ND high nibble.
    for (int t = 0; t < 8; t++) begin
      sel = (t >= 6);
      ni = $urandom_range(1, 12);
      nd = $urandom_range(0, 6);
      ni_byte = ni;
      stream.delete();
      stream.push_back(8'(ni_byte));
      for (int k = 0; k < ni; k++) stream.push_back(8'($urandom));
      stream.push_back(8'(nd));
      stream.push_back(8'($urandom_range(0, 15) * 16));
      for (int k = 0; k < nd * (sel ? 3 : 2); k++) stream.push_back(8'($urandom));
      run_load("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    end

    // 24-bit words on the two-core instance.
    sel = 1'b1;
    stream = '{8'h01, 8'h5A, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03};
    run_load("w24_word", 1'b0, 1'b0, 1'b0);
    sel = 1'b0;

    // Reset in the middle of a load abandons it; the next load restarts at address 0.
    start = 1'b1; step(); start = 1'b0;
    send_byte(8'h03, 1'b0, 1'b0);
    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0);
    rstN = 1'b0;
    step();
    clear_got();
    @(negedge clk);
    check_idle_outputs("midreset");
    step();
    rstN = 1'b1;
    repeat (3) step();
    check("midreset_no_writes", got_ia.size() + got_da.size(), 0);
    stream = '{8'h02, 8'h55, 8'h66, 8'h00, 8'h00};
    run_load("after_reset", 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
